// File: rtl/aq_djpeg_zz_read_ctrl.sv
// aq_djpeg_zz_read_ctrl: zigzag bank buffer read sequencer feeding the IDCT.
// Waits for a filled bank and an idle IDCT, then issues 2**ADDR_W read strobes.
// Data returns one cycle after each strobe. IdctEnable, IdctAddress and
// IdctColor are aligned with that returned data.
// Ports:
//   clk, rst (async, active-low), DataInit (sync restart)
//   ZzOutEnable, ZzOutColor, ZzOutRead, ZzOutAddress : buffer side
//   IdctIdle, IdctReady, IdctStart, IdctEnable, IdctAddress, IdctColor, IdctEnd
//   Busy : sequencer not idle
// Optional feature macro AQ_DJPEG_ZZRD_BLKCNT_EN adds BlockCount[15:0] and
// ColorError.
module aq_djpeg_zz_read_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int GAP_CYCLES = 0
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              DataInit,
  input  logic              ZzOutEnable,
  input  logic [2:0]        ZzOutColor,
  output logic              ZzOutRead,
  output logic [ADDR_W-1:0] ZzOutAddress,
  input  logic              IdctIdle,
  input  logic              IdctReady,
  output logic              IdctStart,
  output logic              IdctEnable,
  output logic [ADDR_W-1:0] IdctAddress,
  output logic [2:0]        IdctColor,
  output logic              IdctEnd,
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
  output logic [15:0]       BlockCount,
  output logic              ColorError,
`endif
  output logic              Busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_GAP,
    S_INIT
  } state_t;

  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] Addr;
  logic [ADDR_W-1:0] addrNext;
  logic [3:0]        gapCnt;
  logic [3:0]        gapNext;
  logic              startNext;
  logic              endNext;
  logic              blockGo;

  assign ZzOutAddress = Addr;
  assign Busy         = (state != S_IDLE);

  always_comb begin
    stateNext = state;
    addrNext  = Addr;
    gapNext   = gapCnt;
    ZzOutRead = 1'b0;
    startNext = 1'b0;
    endNext   = 1'b0;
    blockGo   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ZzOutEnable && IdctIdle && gapCnt == 4'd0) begin
          stateNext = S_READ;
          addrNext  = '0;
          startNext = 1'b1;
          blockGo   = 1'b1;
        end
      end
      S_READ: begin
        ZzOutRead = IdctReady;
        if (IdctReady) begin
          addrNext = Addr + ADDR_W'(1);
          if (Addr == '1)
            stateNext = S_DRAIN;
        end
      end
      S_DRAIN: begin
        endNext = 1'b1;
        if (GAP_LD != 4'd0) begin
          stateNext = S_GAP;
          gapNext   = GAP_LD;
        end else begin
          stateNext = S_IDLE;
        end
      end
      S_GAP: begin
        gapNext = gapCnt - 4'd1;
        if (gapCnt <= 4'd1) begin
          stateNext = S_IDLE;
          gapNext   = 4'd0;
        end
      end
      S_INIT:  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
    // restart overrides everything, including the strobe
    if (DataInit) begin
      stateNext = S_INIT;
      addrNext  = '0;
      gapNext   = 4'd0;
      ZzOutRead = 1'b0;
      startNext = 1'b0;
      endNext   = 1'b0;
      blockGo   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      Addr        <= '0;
      gapCnt      <= 4'd0;
      IdctStart   <= 1'b0;
      IdctEnd     <= 1'b0;
      IdctEnable  <= 1'b0;
      IdctAddress <= '0;
      IdctColor   <= 3'd0;
    end else begin
      state       <= stateNext;
      Addr        <= addrNext;
      gapCnt      <= gapNext;
      IdctStart   <= startNext;
      IdctEnd     <= endNext;
      IdctEnable  <= ZzOutRead;
      IdctAddress <= ZzOutAddress;
      if (blockGo)
        IdctColor <= ZzOutColor;
    end
  end

`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BlockCount <= 16'd0;
      ColorError <= 1'b0;
    end else if (DataInit) begin
      BlockCount <= 16'd0;
      ColorError <= 1'b0;
    end else begin
      if (IdctEnd)
        BlockCount <= BlockCount + 16'd1;
      if (blockGo && ZzOutColor > 3'd5)
        ColorError <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_aq_djpeg_zz_read_ctrl.sv
// tb_aq_djpeg_zz_read_ctrl: scoreboard bench for the zigzag read sequencer.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_aq_djpeg_zz_read_ctrl;

  logic       rst;
  logic       clk;
  logic       DataInit;
  logic       ZzOutEnable;
  logic [2:0] ZzOutColor;
  logic       ZzOutRead;
  logic [4:0] ZzOutAddress;
  logic       IdctIdle;
  logic       IdctReady;
  logic       IdctStart;
  logic       IdctEnable;
  logic [4:0] IdctAddress;
  logic [2:0] IdctColor;
  logic       IdctEnd;
  logic       Busy;
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
  logic [15:0] BlockCount;
  logic        ColorError;
`endif

  aq_djpeg_zz_read_ctrl #(
    .ADDR_W(5),
    .GAP_CYCLES(3)
  ) dut (
    .rst(rst),
    .clk(clk),
    .DataInit(DataInit),
    .ZzOutEnable(ZzOutEnable),
    .ZzOutColor(ZzOutColor),
    .ZzOutRead(ZzOutRead),
    .ZzOutAddress(ZzOutAddress),
    .IdctIdle(IdctIdle),
    .IdctReady(IdctReady),
    .IdctStart(IdctStart),
    .IdctEnable(IdctEnable),
    .IdctAddress(IdctAddress),
    .IdctColor(IdctColor),
    .IdctEnd(IdctEnd),
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    .BlockCount(BlockCount),
    .ColorError(ColorError),
`endif
    .Busy(Busy)
  );

  typedef struct {
    int cyc;
    int addr;
    int color;
  } ev_t;

  ev_t readQ[$];
  ev_t dataQ[$];
  ev_t startQ[$];
  ev_t endQ[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d",
               name, cyc, act, exp);
    end
  endtask

  task automatic unexp(input string name, input int val);
    tests++;
    fails++;
    $display("FAIL %s unexpected at cycle %0d: got value %0d, want no event",
             name, cyc, val);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick();
  endtask

  // s: first read cycle; stall of stallLen cycles before address stallAt
  task automatic expectBlock(input int s, input int color,
                             input int stallAt, input int stallLen,
                             input int nReads, input int nData,
                             input bit withEnd, output int lastRd);
    int rc;
    startQ.push_back('{s, 0, color});
    for (int a = 0; a < nReads; a++) begin
      rc = s + a + ((a >= stallAt) ? stallLen : 0);
      readQ.push_back('{rc, a, 0});
      if (a < nData)
        dataQ.push_back('{rc + 1, a, color});
    end
    lastRd = s + 31 + stallLen;
    if (withEnd)
      endQ.push_back('{lastRd + 2, 0, 0});
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (ZzOutRead) begin
        if (readQ.size() == 0) unexp("read", int'(ZzOutAddress));
        else begin
          e = readQ.pop_front();
          chk("readCyc", cyc, e.cyc);
          chk("readAddr", int'(ZzOutAddress), e.addr);
        end
      end
      if (IdctEnable) begin
        if (dataQ.size() == 0) unexp("data", int'(IdctAddress));
        else begin
          e = dataQ.pop_front();
          chk("dataCyc", cyc, e.cyc);
          chk("dataAddr", int'(IdctAddress), e.addr);
          chk("dataColor", int'(IdctColor), e.color);
        end
      end
      if (IdctStart) begin
        if (startQ.size() == 0) unexp("start", int'(IdctColor));
        else begin
          e = startQ.pop_front();
          chk("startCyc", cyc, e.cyc);
          chk("startColor", int'(IdctColor), e.color);
        end
      end
      if (IdctEnd) begin
        if (endQ.size() == 0) unexp("end", 1);
        else begin
          e = endQ.pop_front();
          chk("endCyc", cyc, e.cyc);
        end
      end
    end
  end

  task automatic chkIdleOutputs(input string tag);
    chk({tag, "Read"}, int'(ZzOutRead), 0);
    chk({tag, "Start"}, int'(IdctStart), 0);
    chk({tag, "Enable"}, int'(IdctEnable), 0);
    chk({tag, "End"}, int'(IdctEnd), 0);
    chk({tag, "Busy"}, int'(Busy), 0);
    chk({tag, "IdctAddr"}, int'(IdctAddress), 0);
    chk({tag, "Color"}, int'(IdctColor), 0);
    chk({tag, "ZzAddr"}, int'(ZzOutAddress), 0);
  endtask

  initial begin
    int c0;
    int s;
    int L;
    int L2;
    rst = 1'b0;
    DataInit = 1'b0;
    ZzOutEnable = 1'b0;
    ZzOutColor = 3'd0;
    IdctIdle = 1'b0;
    IdctReady = 1'b0;
    repeat (3) tick();
    chkIdleOutputs("rst");
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    chk("rstBlkCnt", int'(BlockCount), 0);
    chk("rstColErr", int'(ColorError), 0);
`endif
    rst = 1'b1;
    tick();
    tick();

    // plain block, colour 2
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    IdctIdle = 1'b1;
    IdctReady = 1'b1;
    ZzOutColor = 3'd2;
    expectBlock(s, 2, 32, 0, 32, 32, 1'b1, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(s + 5);
    chk("busyMid", int'(Busy), 1);
    waitUntil(L + 5);

    // stall of 5 cycles at address 10
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd5;
    expectBlock(s, 5, 10, 5, 32, 32, 1'b1, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(s + 10);
    IdctReady = 1'b0;
    waitUntil(s + 15);
    IdctReady = 1'b1;
    waitUntil(L + 5);

    // back-to-back banks through the gap
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd1;
    expectBlock(s, 1, 32, 0, 32, 32, 1'b1, L);
    expectBlock(L + 6, 4, 32, 0, 32, 32, 1'b1, L2);
    tick();
    ZzOutColor = 3'd4;
    waitUntil(L + 6);
    ZzOutEnable = 1'b0;
    waitUntil(L2 + 5);

    // IDCT busy holds off the start
    IdctIdle = 1'b0;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd3;
    repeat (20) tick();
    chk("holdBusy", int'(Busy), 0);
    c0 = cyc;
    s = c0 + 1;
    IdctIdle = 1'b1;
    expectBlock(s, 3, 32, 0, 32, 32, 1'b1, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(L + 5);
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    chk("blkCnt5", int'(BlockCount), 5);
    chk("colErr0", int'(ColorError), 0);
`endif

    // DataInit at address 17
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd6;
    expectBlock(s, 6, 32, 0, 17, 17, 1'b0, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(s + 17);
    DataInit = 1'b1;
    #1;
    chk("initNoRead", int'(ZzOutRead), 0);
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    chk("colErr1", int'(ColorError), 1);
`endif
    tick();
    DataInit = 1'b0;
    chk("initBusy", int'(Busy), 1);
    tick();
    chk("initIdle", int'(Busy), 0);
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    chk("initBlkCnt", int'(BlockCount), 0);
    chk("initColErr", int'(ColorError), 0);
`endif
    tick();

    // restart after DataInit begins at address 0
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd0;
    expectBlock(s, 0, 32, 0, 32, 32, 1'b1, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(L + 5);
`ifdef AQ_DJPEG_ZZRD_BLKCNT_EN
    chk("blkCnt1", int'(BlockCount), 1);
`endif

    // async reset mid-block
    c0 = cyc;
    s = c0 + 1;
    ZzOutEnable = 1'b1;
    ZzOutColor = 3'd7;
    expectBlock(s, 7, 32, 0, 5, 4, 1'b0, L);
    tick();
    ZzOutEnable = 1'b0;
    waitUntil(s + 5);
    rst = 1'b0;
    #1;
    chkIdleOutputs("midRst");
    tick();
    tick();
    rst = 1'b1;
    repeat (4) tick();
    chk("postRstBusy", int'(Busy), 0);

    chk("readQLeft", readQ.size(), 0);
    chk("dataQLeft", dataQ.size(), 0);
    chk("startQLeft", startQ.size(), 0);
    chk("endQLeft", endQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
